// File: rtl/subleq_ctrl_if.sv
// RAM control bus of the SUBLEQ sequencer: the read/write select, the enable and the address.
// The data lines stay a plain inout port on the sequencer because they are tri-stated.
interface subleq_ctrl_if;
  logic       mem_ctl;
  logic       mem_ena;
  logic [7:0] mem_adr;

  modport master (output mem_ctl, output mem_ena, output mem_adr);
  modport slave  (input mem_ctl, input mem_ena, input mem_adr);
endinterface

// File: rtl/subleq_ctrl.sv
// SUBLEQ sequencer: fetch A/B/C, read mem[A]/mem[B], write mem[B]-mem[A], branch if <= 0.
// Optional single-step gating after each instruction: define SUBLEQ_STEP_EN.
module subleq_ctrl #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] HALT_ADDR = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef SUBLEQ_STEP_EN
  input  logic          step,
`endif
  subleq_ctrl_if.master bus,
  inout  wire  [7:0]    mem_dat,
  output logic [7:0]    pc,
  output logic          halted,
  output logic          instr_done
);

  typedef enum logic [3:0] {
    StIdle, StFa, StFb, StFc, StRa, StRb, StWs, StWr, StHalt
`ifdef SUBLEQ_STEP_EN
    , StPause
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0] ma_q, ma_d, mb_q, mb_d;
  logic       ctl_q, ctl_d, ena_q, ena_d;
  logic [7:0] adr_q, adr_d, dat_q, dat_d;
  logic       halted_q, halted_d, done_q, done_d;
  logic [7:0] res;
  logic       taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 8'h00;
      ma_q     <= 8'h00;
      mb_q     <= 8'h00;
      ctl_q    <= 1'b1;
      ena_q    <= 1'b0;
      adr_q    <= 8'h00;
      dat_q    <= 8'h00;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      ctl_q    <= ctl_d;
      ena_q    <= ena_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  // Read data is captured at the edge that ends each read cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    res     = mb_q - ma_q;
    taken   = res[7] | (res == 8'h00);
    case (state_q)
      StIdle: if (start) state_d = StFa;
      StFa: begin
        a_d     = mem_dat;
        state_d = StFb;
      end
      StFb: begin
        b_d     = mem_dat;
        state_d = StFc;
      end
      StFc: begin
        c_d     = mem_dat;
        state_d = StRa;
      end
      StRa: begin
        ma_d    = mem_dat;
        state_d = StRb;
      end
      StRb: begin
        mb_d    = mem_dat;
        state_d = StWs;
      end
      StWs: state_d = StWr;
      StWr: begin
        if (taken && (c_q == HALT_ADDR)) begin
          state_d = StHalt;
        end else begin
          pc_d = taken ? c_q : pc_q + 8'd3;
`ifdef SUBLEQ_STEP_EN
          state_d = StPause;
`else
          state_d = StFa;
`endif
        end
      end
`ifdef SUBLEQ_STEP_EN
      StPause: if (step) state_d = StFa;
`endif
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ctl_d = 1'b1;
    ena_d = 1'b0;
    adr_d = adr_q;
    dat_d = dat_q;
    case (state_d)
      StFa: begin
        ena_d = 1'b1;
        adr_d = pc_d;
      end
      StFb: begin
        ena_d = 1'b1;
        adr_d = pc_d + 8'd1;
      end
      StFc: begin
        ena_d = 1'b1;
        adr_d = pc_d + 8'd2;
      end
      StRa: begin
        ena_d = 1'b1;
        adr_d = a_d;
      end
      StRb: begin
        ena_d = 1'b1;
        adr_d = b_d;
      end
      // Setup cycle: data and address settle while ena is still low.
      StWs: begin
        ctl_d = 1'b0;
        adr_d = b_d;
        dat_d = mb_d - ma_d;
      end
      StWr: begin
        ctl_d = 1'b0;
        ena_d = 1'b1;
        adr_d = b_d;
      end
      default: ;
    endcase
  end

  assign halted_d = (state_d == StHalt);
  assign done_d   = (state_d == StWr);

  assign bus.mem_ctl = ctl_q;
  assign bus.mem_ena = ena_q;
  assign bus.mem_adr = adr_q;
  assign mem_dat     = ctl_q ? 8'hzz : dat_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign instr_done  = done_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: behavioural RAM, directed SUBLEQ programs, random programs checked
// against an instruction-level reference model, and a bus-discipline monitor.
module tb_subleq_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
`ifdef SUBLEQ_STEP_EN
  logic step  = 1'b1;
  localparam int Lat = 8;  // PAUSE adds one cycle between back-to-back instructions
`else
  localparam int Lat = 7;
`endif

  wire  [7:0] mem_dat;
  logic [7:0] pc;
  logic       halted, instr_done;

  subleq_ctrl_if bus_if ();

  subleq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef SUBLEQ_STEP_EN
    .step       (step),
`endif
    .bus        (bus_if),
    .mem_dat    (mem_dat),
    .pc         (pc),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  // RAM: asynchronous read; the bus floats to 00 (keeper) when read-selected but disabled,
  // so a sequencer driving while ctl = 1 shows up as a corrupted value.
  logic [7:0] mem  [256];
  logic [7:0] prog [256];
  logic       load = 1'b0;

  assign mem_dat = bus_if.mem_ctl ? (bus_if.mem_ena ? mem[bus_if.mem_adr] : 8'h00) : 8'hzz;

  always @(posedge clk) begin
    if (load) mem <= prog;
    else if (!bus_if.mem_ctl && bus_if.mem_ena) mem[bus_if.mem_adr] <= mem_dat;
  end

  int   checks   = 0;
  int   failures = 0;
  int   mon_errs = 0;
  logic prev_ctl = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ctl <= 1'b1;
    end else begin
      if (bus_if.mem_ctl &&
          mem_dat !== (bus_if.mem_ena ? mem[bus_if.mem_adr] : 8'h00)) begin
        mon_errs <= mon_errs + 1;
        $display("FAIL bus_release: mem_dat=%h while ctl=1 ena=%b", mem_dat, bus_if.mem_ena);
      end
      if (prev_ctl && !bus_if.mem_ctl && bus_if.mem_ena) begin
        mon_errs <= mon_errs + 1;
        $display("FAIL ena_on_ctl_fall: ena=1 in cycle where ctl fell");
      end
      prev_ctl <= bus_if.mem_ctl;
    end
  end

  // Instruction-level reference machine.
  logic [7:0] rmem [256];
  logic [7:0] rpc;
  logic       rhalt;

  task automatic model_step(output logic [7:0] baddr, output logic [7:0] r);
    logic [7:0] a, b, c, p1, p2;
    p1 = rpc + 8'd1;
    p2 = rpc + 8'd2;
    a  = rmem[rpc];
    b  = rmem[p1];
    c  = rmem[p2];
    r  = rmem[b] - rmem[a];
    rmem[b] = r;
    baddr = b;
    if ($signed(r) <= 0) begin
      if (c == 8'hFF) rhalt = 1'b1;
      else rpc = c;
    end else begin
      rpc = rpc + 8'd3;
    end
  endtask

  task automatic boot();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    load = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
    rst_n = 1'b1;
    rmem  = prog;
    rpc   = 8'h00;
    rhalt = 1'b0;
  endtask

  task automatic load_single(input logic [7:0] ma, input logic [7:0] mb, input logic [7:0] c);
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    prog[0]  = 8'h0A;
    prog[1]  = 8'h0B;
    prog[2]  = c;
    prog[10] = ma;
    prog[11] = mb;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (instr_done !== 1'b1 && cyc < 40);
  endtask

  // Starts the machine and watches ten cycles; the first instruction has committed by then.
  task automatic run_first(output int first, output int pulses);
    first  = 0;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (instr_done === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic test_reset();
    boot();
    #1;
    checks++;
    if (bus_if.mem_ena !== 1'b0 || bus_if.mem_ctl !== 1'b1 || pc !== 8'h00 ||
        halted !== 1'b0 || instr_done !== 1'b0 || bus_if.mem_adr !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle: ena=%b ctl=%b pc=%h halted=%b done=%b adr=%h, need 0 1 00 0 0 00",
               bus_if.mem_ena, bus_if.mem_ctl, pc, halted, instr_done, bus_if.mem_adr);
    end
  endtask

  task automatic test_single(input string name, input logic [7:0] ma, input logic [7:0] mb,
                             input logic [7:0] c, input logic [7:0] exp_res,
                             input logic [7:0] exp_pc, input logic exp_halt);
    int first, pulses;
    load_single(ma, mb, c);
    boot();
    run_first(first, pulses);
    checks++;
    if (mem[11] !== exp_res) begin
      failures++;
      $display("FAIL %s_result: mem[0B]=%h need %h", name, mem[11], exp_res);
    end
    checks++;
    if (pc !== exp_pc) begin
      failures++;
      $display("FAIL %s_pc: pc=%h need %h", name, pc, exp_pc);
    end
    checks++;
    if (first != 7 || pulses != 1) begin
      failures++;
      $display("FAIL %s_done: first pulse cycle=%0d pulses=%0d need 7 and 1", name, first, pulses);
    end
    checks++;
    if (halted !== exp_halt) begin
      failures++;
      $display("FAIL %s_halted: halted=%b need %b", name, halted, exp_halt);
    end
  endtask

  task automatic test_halt_sticky();
    logic ena_seen = 1'b0;
    test_single("halt", 8'h05, 8'h05, 8'hFF, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = (k % 3 == 0);
      if (bus_if.mem_ena !== 1'b0) ena_seen = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (ena_seen || halted !== 1'b1 || pc !== 8'h00) begin
      failures++;
      $display("FAIL halt_sticky: ena_seen=%b halted=%b pc=%h need 0 1 00", ena_seen, halted, pc);
    end
  endtask

  task automatic setup_wrap();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    prog[8'h00] = 8'h30; prog[8'h01] = 8'h31; prog[8'h02] = 8'hFE;
    prog[8'h30] = 8'h01; prog[8'h31] = 8'h01;
    prog[8'hFE] = 8'h40; prog[8'hFF] = 8'h41;
    prog[8'h40] = 8'h01; prog[8'h41] = 8'h80;
  endtask

  task automatic test_wrap();
    int cyc;
    setup_wrap();
    boot();
    @(negedge clk);
    start = 1'b1;
    wait_done(cyc);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 8'hFE) begin
      failures++;
      $display("FAIL wrap_branch: pc=%h need fe", pc);
    end
    wait_done(cyc);
    @(posedge clk);
    #1;
    checks++;
    if (mem[8'h41] !== 8'h7F || pc !== 8'h01) begin
      failures++;
      $display("FAIL wrap_signed: mem[41]=%h pc=%h need 7f 01", mem[8'h41], pc);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    setup_wrap();
    boot();
    @(negedge clk);
    start = 1'b1;
    wait_done(cyc);
    start = 1'b0;
    wait_done(cyc);
    rst_n = 1'b0;  // lands in the second write-commit cycle, with pc = fe
    #1;
    checks++;
    if (bus_if.mem_ena !== 1'b0 || bus_if.mem_ctl !== 1'b1 || mem_dat !== 8'h00 ||
        pc !== 8'h00 || halted !== 1'b0 || instr_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_midrun: ena=%b ctl=%b dat=%h pc=%h halted=%b done=%b",
               bus_if.mem_ena, bus_if.mem_ctl, mem_dat, pc, halted, instr_done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_in_ws();
    logic found = 1'b0;
    load_single(8'h03, 8'h05, 8'h20);
    boot();
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus_if.mem_ctl === 1'b0 && bus_if.mem_ena === 1'b0) found = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!found || mem[11] !== 8'h05 || bus_if.mem_ena !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ws: found=%b mem[0B]=%h ena=%b need 1 05 0",
               found, mem[11], bus_if.mem_ena);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int         cyc, bad;
    logic [7:0] baddr, r;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 256; i++) prog[i] = 8'($urandom_range(255));
      boot();
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 20 && !rhalt; n++) begin
        model_step(baddr, r);
        wait_done(cyc);
        start = 1'b0;
        checks++;
        if (cyc != ((n == 0) ? 7 : Lat)) begin
          failures++;
          $display("FAIL rand_latency: run %0d instr %0d took %0d cycles need %0d",
                   s, n, cyc, (n == 0) ? 7 : Lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem[baddr] !== r) begin
          failures++;
          $display("FAIL rand_write: run %0d instr %0d mem[%h]=%h need %h", s, n, baddr,
                   mem[baddr], r);
        end
        checks++;
        if (pc !== rpc || halted !== rhalt) begin
          failures++;
          $display("FAIL rand_pc: run %0d instr %0d pc=%h halted=%b need %h %b", s, n, pc,
                   halted, rpc, rhalt);
        end
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand_memory: run %0d has %0d differing bytes need 0", s, bad);
      end
    end
  endtask

  task automatic test_bus_monitor();
    checks++;
    if (mon_errs != 0) begin
      failures++;
      $display("FAIL bus_monitor: %0d violations need 0", mon_errs);
    end
  endtask

  initial begin
    test_reset();
    test_single("not_taken", 8'h03, 8'h05, 8'h20, 8'h02, 8'h03, 1'b0);
    test_single("taken_zero", 8'h05, 8'h05, 8'h20, 8'h00, 8'h20, 1'b0);
    test_single("taken_neg", 8'h06, 8'h05, 8'h20, 8'hFF, 8'h20, 1'b0);
    test_single("ovf_wrap", 8'h01, 8'h80, 8'h20, 8'h7F, 8'h03, 1'b0);
    test_halt_sticky();
    test_wrap();
    test_reset_midrun();
    test_reset_in_ws();
    test_random();
    test_bus_monitor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/subleq_ctrl.md
Name: subleq_ctrl

Overview:
- Sequencer for the 8-bit SUBLEQ machine; sits directly upstream of the single-port 8-bit asynchronous RAM and is its only bus master.
- Fetches instruction triple A, B, C at PC, PC+1, PC+2, reads mem[A] and mem[B], writes mem[B] - mem[A] back to B, and branches to C when the result is <= 0 (signed), else PC += 3.
- Drives the RAM's ctl/ena/adr and tri-state data bus with write-safe sequencing.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ADDR, 8'hFF, taken-branch target that halts the machine instead of jumping.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; leaves IDLE when sampled high.
- mem_ctl  output  1  RAM control: 1 = read, 0 = write.
- mem_ena  output  1  RAM enable, active high.
- mem_adr  output  8  RAM address.
- mem_dat  inout  8  RAM data; driven by this block only while mem_ctl = 0, else high-Z.
- pc  output  8  current program counter.
- halted  output  1  sticky halt flag.
- instr_done  output  1  one-cycle pulse, high during the write-commit cycle of each instruction.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, pc = RESET_PC, mem_ctl = 1, mem_ena = 0, mem_adr = 0, mem_dat = Z.
  - halted = 0, instr_done = 0, internal A/B/C/ma/mb = 0.
- All bus outputs are registered. Each state below describes the bus contents during that cycle. Read data is sampled from mem_dat at the rising edge that ends the cycle.
- States and transitions:
  - IDLE: ena = 0, ctl = 1. Go to FA when start = 1.
  - FA: ctl = 1, ena = 1, adr = pc. Capture A. Go to FB.
  - FB: adr = pc+1. Capture B. Go to FC.
  - FC: adr = pc+2. Capture C. Go to RA.
  - RA: adr = A. Capture ma. Go to RB.
  - RB: adr = B. Capture mb. Go to WS.
  - WS (write setup): ctl = 0, ena = 0, adr = B, mem_dat driven with res = mb - ma (mod 256). Go to WR.
  - WR (commit): ctl = 0, ena = 1, adr = B, data still driven, instr_done = 1. Ena rises with adr and data already stable. At the end of WR, update pc and go to FA, or to HALT.
  - HALT: ctl = 1, ena = 0, halted = 1. Stays here until reset; start is ignored.
- Latency is exactly 7 clocks per instruction, FA through WR. start is ignored outside IDLE.
- Branch rule:
  - Taken when res[7] = 1 or res == 0.
  - Taken and C == HALT_ADDR: go to HALT, pc unchanged.
  - Taken otherwise: pc = C.
  - Not taken: pc = pc + 3, modulo 256; wraps, e.g. 8'hFE -> 8'h01.
- Fetch addresses pc+1 and pc+2 also wrap modulo 256.
- Arithmetic is 8-bit two's complement with no overflow detection; only res bits decide the branch. Example: mb = 8'h80, ma = 8'h01 gives res = 8'h7F, not taken.
- Bus rules:
  - mem_dat is never driven while mem_ctl = 1.
  - mem_ena is never high in the cycle in which mem_ctl falls, so no write is triggered with stale data.
- Reset mid-operation: outputs go to reset values immediately. A reset asserted during WS guarantees no write, since ena has not risen. A reset during WR may or may not have committed the write.

Optional Feature:
- Macro SUBLEQ_STEP_EN.
- When defined:
  - Extra input step (1 bit) and extra state PAUSE (ctl = 1, ena = 0).
  - After WR the FSM enters PAUSE, unless it is halting.
  - It proceeds to FA on the first clock where step = 1; step is level-sampled, so one cycle high advances one instruction.
- When undefined: no step port; WR goes directly to FA.

Test Plan:
- Reset: hold rst_n = 0 mid-run -> mem_ena = 0, mem_ctl = 1, mem_dat = Z, pc = RESET_PC, halted = 0, instr_done = 0.
- Not taken: mem[0..2] = {8'h0A, 8'h0B, 8'h20}, mem[10] = 3, mem[11] = 5, pulse start -> 7 cycles later mem[11] = 2, pc = 8'h03, exactly one instr_done pulse.
- Taken on zero: mem[10] = 5, mem[11] = 5 -> mem[11] = 0, pc = 8'h20. Taken on negative: mem[10] = 6 -> mem[11] = 8'hFF, pc = 8'h20.
- Signed wrap and PC wrap: RESET_PC = 8'hFE, triple at FE/FF/00 with mb = 8'h80, ma = 8'h01 -> mem[B] = 8'h7F, pc = 8'h01.
- Halt: C = 8'hFF with a taken result -> write still committed, halted = 1, pc unchanged, mem_ena stays 0, start pulses ignored.
- Bus safety and reset-in-WS: monitor asserts mem_dat = Z whenever mem_ctl = 1, and no ena = 1 in a ctl falling cycle. Assert rst_n during WS -> target location unchanged.
